data_mem_responder: RTL and testbench

Memory-side responder for the CPU core's data port. It accepts one load or store at a time using the core's request signals: enable, 4-bit byte write strobes, address and write data. It serves each request from an internal word-addressed SRAM after a programmable number of wait states. It holds the core stalled until the read data is valid or the write is committed, and sits between the core top level and the SoC memory map.

---
 rtl/data_mem_pkg.sv | 35 +++
 rtl/sram_bank.sv | 28 ++
 rtl/data_mem_responder.sv | 118 +++++++++++
 tb/tb_data_mem_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-port memory responder and the core's store unit.
package data_mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Byte address to word index; callers truncate to their array depth.
    function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

    // Replace only the strobed byte lanes of old_w with those of new_w.
    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] merged;
        merged = old_w;
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_bank.sv
// Single-port word array with per-byte write enables and a registered read port.
module sram_bank
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [STRB_W-1:0] be_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage is deliberately never reset; read returns the pre-write word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (be_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: accepts one load/store, waits WAIT cycles, then commits
// against the SRAM and releases the core stall for a single DONE cycle.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic [STRB_W-1:0] mem_write_en,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_stall,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [STRB_W-1:0] strb_q, strb_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q;

    logic [ADDR_W-1:0] sram_addr;
    logic [STRB_W-1:0] sram_be;
    logic [DATA_W-1:0] sram_rdata;

    // State and request-latch registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            strb_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Next state, counter, request latch and completion data.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_en) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_W'(WAIT);
                    idx_d   = ADDR_W'(word_index(addr));
                    strb_d  = mem_write_en;
                    wdata_d = wdata;
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_DONE;
                    // A read has all strobes clear, so the merge passes the array word through.
                    rdata_d = lane_merge(sram_rdata, wdata_q, strb_q);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Stall and SRAM controls; in IDLE the SRAM reads the incoming address so WAIT=0 has data ready.
    always_comb begin
        mem_stall = 1'b0;
        sram_addr = idx_q;
        sram_be   = '0;
        unique case (state_q)
            ST_IDLE: begin
                mem_stall = rst & mem_en;
                sram_addr = ADDR_W'(word_index(addr));
            end
            ST_BUSY: begin
                mem_stall = 1'b1;
                if (cnt_q == '0) begin
                    sram_be = strb_q;
                end
            end
            default: mem_stall = 1'b0;
        endcase
    end

    sram_bank #(
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk     (clk),
        .addr_i  (sram_addr),
        .be_i    (sram_be),
        .wdata_i (wdata_q),
        .rdata_o (sram_rdata)
    );

    assign rdata = rdata_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance at WAIT=2 and one at WAIT=0.
module tb_data_mem_responder;

    localparam int unsigned AW = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_v   [2];
    logic [3:0]  we_v   [2];
    logic [31:0] addr_v [2];
    logic [31:0] wd_v   [2];

    logic [31:0] rd0, rd1;
    logic        st0, st1, bz0, bz1;
    logic [31:0] rd_m    [2];
    logic        stall_m [2];
    logic        busy_m  [2];

    assign rd_m[0] = rd0;
    assign rd_m[1] = rd1;
    assign stall_m[0] = st0;
    assign stall_m[1] = st1;
    assign busy_m[0] = bz0;
    assign busy_m[1] = bz1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(AW), .WAIT(2)) dut_w2 (
        .clk(clk), .rst(rst), .mem_en(en_v[0]), .mem_write_en(we_v[0]),
        .addr(addr_v[0]), .wdata(wd_v[0]), .rdata(rd0), .mem_stall(st0), .busy(bz0)
    );

    data_mem_responder #(.ADDR_W(AW), .WAIT(0)) dut_w0 (
        .clk(clk), .rst(rst), .mem_en(en_v[1]), .mem_write_en(we_v[1]),
        .addr(addr_v[1]), .wdata(wd_v[1]), .rdata(rd1), .mem_stall(st1), .busy(bz1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Count stall cycles from the current cycle until DONE (busy high, stall low).
    task automatic run_to_done(input int sel, output logic [31:0] rd, output int nstall,
                               output bit first_stall, output bit ok);
        bit done;
        done = 0; nstall = 0; first_stall = 0; ok = 0; rd = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (c == 0) first_stall = stall_m[sel];
            if (stall_m[sel]) nstall++;
            else if (busy_m[sel]) begin
                done = 1;
                rd = rd_m[sel];
            end
        end
        ok = done;
    endtask

    task automatic access(input int sel, input logic [3:0] we, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output int nstall,
                          output bit ok);
        bit fs;
        @(posedge clk); #1;
        en_v[sel] = 1'b1; we_v[sel] = we; addr_v[sel] = a; wd_v[sel] = wd;
        run_to_done(sel, rd, nstall, fs, ok);
        @(posedge clk); #1;
        en_v[sel] = 1'b0; we_v[sel] = 4'h0;
    endtask

    function automatic logic [31:0] ref_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    typedef struct {
        int          sel;
        logic [3:0]  we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_stall;
    } vec_t;

    vec_t        tbl [10];
    logic [31:0] model [2][int];
    int          pool  [2][8];

    initial begin
        logic [31:0] rd;
        int          ns;
        bit          ok, fs;

        tbl[0] = '{0, 4'hF, 32'h40,       32'hDEADBEEF, 32'hDEADBEEF, 4};
        tbl[1] = '{0, 4'h0, 32'h40,       32'h0,        32'hDEADBEEF, 4};
        tbl[2] = '{0, 4'h4, 32'h40,       32'h00AA0000, 32'hDEAABEEF, 4};
        tbl[3] = '{0, 4'h0, 32'h40,       32'h0,        32'hDEAABEEF, 4};
        tbl[4] = '{1, 4'hF, 32'h10,       32'h1,        32'h1,        2};
        tbl[5] = '{1, 4'h0, 32'h13,       32'h0,        32'h1,        2};
        tbl[6] = '{1, 4'h0, 32'h10 + (32'd4 << AW), 32'h0, 32'h1,     2};
        tbl[7] = '{1, 4'h0, 32'hFFFFF012, 32'h0,        32'h1,        2};
        tbl[8] = '{1, 4'h3, 32'h10,       32'hFFFFABCD, 32'h0000ABCD, 2};
        tbl[9] = '{1, 4'h0, 32'h10,       32'h0,        32'h0000ABCD, 2};

        // Reset held with a request pending.
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            en_v[s] = 1'b0; we_v[s] = 4'h0; addr_v[s] = '0; wd_v[s] = '0;
        end
        en_v[0] = 1'b1; we_v[0] = 4'hF; addr_v[0] = 32'h80; wd_v[0] = 32'h0;
        repeat (3) @(negedge clk);
        check("reset rdata", rd0, 32'h0);
        check("reset stall", 32'(st0), 32'h0);
        check("reset busy", 32'(bz0), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        run_to_done(0, rd, ns, fs, ok);
        check("post-reset stall same cycle", 32'(fs), 32'h1);
        check("post-reset access done", 32'(ok), 32'h1);
        check("post-reset stall cycles", 32'(ns), 32'd4);
        check("post-reset write rdata", rd, 32'h0);
        @(posedge clk); #1;
        en_v[0] = 1'b0; we_v[0] = 4'h0;

        for (int i = 0; i < 10; i++) begin
            access(tbl[i].sel, tbl[i].we, tbl[i].a, tbl[i].wd, rd, ns, ok);
            check($sformatf("vec%0d done", i), 32'(ok), 32'h1);
            check($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d stall cycles", i), 32'(ns), 32'(tbl[i].exp_stall));
        end

        // Back-to-back reads with mem_en held high throughout.
        begin
            logic [31:0] b_addr [3];
            logic [31:0] b_exp  [3];
            int k, cyc, lows, last;
            b_addr[0] = 32'h40; b_addr[1] = 32'h80; b_addr[2] = 32'h40;
            b_exp[0] = 32'hDEAABEEF; b_exp[1] = 32'h0; b_exp[2] = 32'hDEAABEEF;
            k = 0; cyc = 0; lows = 0; last = 0;
            @(posedge clk); #1;
            en_v[0] = 1'b1; we_v[0] = 4'h0; addr_v[0] = b_addr[0];
            while (k < 3 && cyc < 100) begin
                @(negedge clk);
                cyc++;
                if (!st0) begin
                    lows++;
                    if (bz0) begin
                        check($sformatf("b2b%0d rdata", k), rd0, b_exp[k]);
                        if (k > 0) check($sformatf("b2b%0d spacing", k), 32'(cyc - last), 32'd5);
                        last = cyc;
                        k++;
                        if (k < 3) begin
                            @(posedge clk); #1;
                            addr_v[0] = b_addr[k];
                        end
                    end
                end
            end
            check("b2b completions", 32'(k), 32'd3);
            check("b2b stall-low cycles", 32'(lows), 32'd3);
            @(posedge clk); #1;
            en_v[0] = 1'b0;
        end

        // Reset asserted during the BUSY phase of a write.
        @(posedge clk); #1;
        en_v[0] = 1'b1; we_v[0] = 4'hF; addr_v[0] = 32'h80; wd_v[0] = 32'h12345678;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid-reset busy", 32'(bz0), 32'h0);
        check("mid-reset stall", 32'(st0), 32'h0);
        check("mid-reset rdata", rd0, 32'h0);
        en_v[0] = 1'b0; we_v[0] = 4'h0;
        @(posedge clk); #1;
        rst = 1'b1;
        access(0, 4'h0, 32'h80, 32'h0, rd, ns, ok);
        check("dropped write done", 32'(ok), 32'h1);
        check("dropped write rdata", rd, 32'h0);
        check("restart stall cycles", 32'(ns), 32'd4);

        // Randomized traffic against an associative-array memory model.
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < 8; p++) begin
                logic [31:0] w;
                pool[s][p] = p * 100 + int'($urandom_range(0, 99));
                w = $urandom();
                access(s, 4'hF, 32'(pool[s][p]) << 2, w, rd, ns, ok);
                model[s][pool[s][p]] = w;
                check($sformatf("init s%0d p%0d", s, p), rd, w);
            end
        end
        for (int n = 0; n < 60; n++) begin
            int          s, idx;
            logic [3:0]  we;
            logic [31:0] a, wd, exp;
            s   = int'($urandom_range(0, 1));
            idx = pool[s][$urandom_range(0, 7)];
            we  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom());
            wd  = $urandom();
            a   = (32'($urandom()) << (AW + 2)) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
            exp = ref_merge(model[s][idx], wd, we);
            model[s][idx] = exp;
            access(s, we, a, wd, rd, ns, ok);
            check($sformatf("rand%0d s%0d a=%h we=%h rdata", n, s, a, we), rd, exp);
            check($sformatf("rand%0d stall cycles", n), 32'(ns), (s == 0) ? 32'd4 : 32'd2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
